// File: rtl/gray_column3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gray_column3_line_buffer
// Purpose  : Buffers the two previous lines of an 8-bit grayscale raster
//            stream and, for every pixel from line 2 onward, emits the
//            vertical 3-pixel column {y-2, y-1, y} with coordinates and
//            frame markers through a single output register.
// Ports    :
//   pclk           pixel clock, all logic on this clock
//   pclk_reset_n   synchronous active-low reset
//   frame_restart  one-cycle pulse, realigns counters to frame start
//   in_data/in_valid/in_ready   input pixel stream (valid/ready)
//   out_col        {row y-2, row y-1, row y} at column out_x
//   out_valid/out_ready         output handshake
//   out_x/out_y    column and bottom-row index of out_col
//   out_sof/out_sol/out_eof     start-of-frame / start-of-line / end-of-frame
//   frames_done    completed-frame counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module gray_column3_line_buffer #(
    parameter int LINE_WIDTH  = 240,
    parameter int FRAME_LINES = 480,
    parameter int PIX_W       = 8
) (
    input  logic                           pclk,
    input  logic                           pclk_reset_n,
    input  logic                           frame_restart,
    input  logic [PIX_W-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [3*PIX_W-1:0]             out_col,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(LINE_WIDTH)-1:0]  out_x,
    output logic [$clog2(FRAME_LINES)-1:0] out_y,
    output logic                           out_sof,
    output logic                           out_sol,
    output logic                           out_eof,
    output logic [7:0]                     frames_done
);

    localparam int X_W = $clog2(LINE_WIDTH);
    localparam int Y_W = $clog2(FRAME_LINES);

    localparam logic [X_W-1:0] C_X_LAST  = X_W'(LINE_WIDTH - 1);
    localparam logic [Y_W-1:0] C_Y_LAST  = Y_W'(FRAME_LINES - 1);
    localparam logic [Y_W-1:0] C_Y_FIRST = Y_W'(2);

    // Line RAMs: lb_a holds line y-1, lb_b holds line y-2
    logic [PIX_W-1:0] lb_a_mem [LINE_WIDTH];
    logic [PIX_W-1:0] lb_b_mem [LINE_WIDTH];
    logic [PIX_W-1:0] rd_a_q;
    logic [PIX_W-1:0] rd_b_q;

    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [7:0]         frames_done_q, frames_done_d;
    logic               out_valid_q, out_valid_d;
    logic [3*PIX_W-1:0] out_col_q, out_col_d;
    logic [X_W-1:0]     out_x_q, out_x_d;
    logic [Y_W-1:0]     out_y_q, out_y_d;
    logic               out_sof_q, out_sof_d;
    logic               out_sol_q, out_sol_d;
    logic               out_eof_q, out_eof_d;

    logic           accept;
    logic [X_W-1:0] x_cur;
    logic [Y_W-1:0] y_cur;
    logic           x_last;
    logic           y_last;
    logic [X_W-1:0] wr_addr;
    logic [X_W-1:0] rd_addr;

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        // No pixel is taken while reset is held, so counters and RAM stay put
        accept  = in_valid && in_ready && pclk_reset_n;
        // A restart in the same cycle as an accept makes that pixel (0,0)
        x_cur   = frame_restart ? '0 : x_q;
        y_cur   = frame_restart ? '0 : y_q;
        x_last  = (x_cur == C_X_LAST);
        y_last  = (y_cur == C_Y_LAST);
        wr_addr = x_cur;

        x_d           = x_q;
        y_d           = y_q;
        frames_done_d = frames_done_q;
        out_valid_d   = out_valid_q;
        out_col_d     = out_col_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_sof_d     = out_sof_q;
        out_sol_d     = out_sol_q;
        out_eof_d     = out_eof_q;

        if (frame_restart) begin
            x_d         = '0;
            y_d         = '0;
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_cur + Y_W'(1);
                if (y_last) begin
                    frames_done_d = frames_done_q + 8'd1;
                end
            end else begin
                x_d = x_cur + X_W'(1);
            end

            if (y_cur >= C_Y_FIRST) begin
                out_valid_d = 1'b1;
                out_col_d   = {rd_b_q, rd_a_q, in_data};
                out_x_d     = x_cur;
                out_y_d     = y_cur;
                out_sof_d   = (x_cur == '0) && (y_cur == C_Y_FIRST);
                out_sol_d   = (x_cur == '0);
                out_eof_d   = x_last && y_last;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!frame_restart && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Look-ahead read: fetch the column the next accepted pixel will use,
        // so the RAM data is already registered when that pixel arrives.
        // The write (to x_cur) and this read never collide because an accept
        // always moves the column on; without an accept nothing is written.
        rd_addr = pclk_reset_n ? x_d : '0;
    end

    always_ff @(posedge pclk) begin
        if (!pclk_reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            frames_done_q <= '0;
            out_valid_q   <= 1'b0;
            out_col_q     <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_sof_q     <= 1'b0;
            out_sol_q     <= 1'b0;
            out_eof_q     <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            frames_done_q <= frames_done_d;
            out_valid_q   <= out_valid_d;
            out_col_q     <= out_col_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_sof_q     <= out_sof_d;
            out_sol_q     <= out_sol_d;
            out_eof_q     <= out_eof_d;
        end
    end

    // Line RAM contents are intentionally not reset
    always_ff @(posedge pclk) begin
        if (accept) begin
            lb_a_mem[wr_addr] <= in_data;
            lb_b_mem[wr_addr] <= rd_a_q;
        end
        rd_a_q <= lb_a_mem[rd_addr];
        rd_b_q <= lb_b_mem[rd_addr];
    end

    assign out_valid   = out_valid_q;
    assign out_col     = out_col_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_sof     = out_sof_q;
    assign out_sol     = out_sol_q;
    assign out_eof     = out_eof_q;
    assign frames_done = frames_done_q;

endmodule
`default_nettype wire

// File: doc/gray_column3_line_buffer.md
Name: gray_column3_line_buffer

Overview:
- Consumes the 8-bit grayscale pixel stream from the DDR3 crop reader on the pixel clock. Input is raster order, crop_width pixels per line, frame_lines lines per frame, valid/ready handshake.
- Holds the two previous lines in on-chip line RAM.
- For every incoming pixel from line 2 onward, emits a vertical 3-pixel column (rows y-2, y-1, y) plus coordinates and frame markers.
- Feeds the block-matching window stage with a single-register valid/ready output.

Parameters:
- line_width, 240, pixels per line; must equal the reader's crop width.
- frame_lines, 480, lines per frame.
- pix_w, 8, bits per pixel.

Ports:
- pclk  in  1  pixel clock; all logic is on this clock.
- pclk_reset_n  in  1  reset, synchronous, active-low.
- frame_restart  in  1  single-cycle pulse; realigns counters to the start of a frame.
- in_data  in  pix_w  incoming pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_col  out  3*pix_w  {row y-2 [23:16], row y-1 [15:8], row y [7:0]} at column out_x.
- out_valid  out  1  out_col and its sidebands are valid.
- out_ready  in  1  downstream accepts the output.
- out_x  out  $clog2(line_width)  column index, 0..line_width-1.
- out_y  out  $clog2(frame_lines)  bottom-row index y, 2..frame_lines-1.
- out_sof  out  1  first column of a frame (x=0, y=2).
- out_sol  out  1  first column of a line (x=0).
- out_eof  out  1  last column of a frame (x=line_width-1, y=frame_lines-1).
- frames_done  out  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset (pclk_reset_n=0, synchronous): x=0, y=0, out_valid=0, frames_done=0, out_col/out_x/out_y=0, out_sof/out_sol/out_eof=0. Line RAM contents are not cleared.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; in_ready=1 during reset is harmless).
  - A pixel is accepted when in_valid && in_ready.
  - out_* hold stable while out_valid && !out_ready.
- Line RAMs: lb_a holds line y-1, lb_b holds line y-2, each line_width x pix_w.
  - On accept at column x: lb_b[x] <= lb_a[x]_old and lb_a[x] <= in_data.
  - Reads must return pre-write data. Implement either as a 1-cycle look-ahead read at address x, or as a registered read with in_data delayed one stage. Either way, external latency is fixed as below.
- Latency: a pixel accepted in cycle T appears on out_col in cycle T+1 with out_valid=1, provided y>=2 at acceptance.
- Lines 0 and 1 are accepted and written to RAM but produce no output; out_valid is cleared once the current output is taken.
- Counters:
  - x increments per accept. At x=line_width-1, x wraps to 0 and y increments.
  - At (line_width-1, frame_lines-1), x and y both wrap to 0 and frames_done increments on that accept.
- Sideband outputs register the x/y of the accepted pixel, not the post-increment value.
- frame_restart:
  - Forces x=0, y=0, out_valid=0 in the same cycle; a pending output is dropped.
  - If a pixel is accepted in the same cycle, it is taken as (0,0) of the new frame (written to RAM, no output) and the next pixel is x=1.
  - frames_done is not incremented by restart.
- Back-pressure: if out_ready is held low, in_ready stays low after one output is buffered and no input is lost. No internal FIFO; the reader's show-ahead FIFO absorbs the stall.
- Reset mid-frame: counters return to 0 and stale RAM data is never emitted, because output only starts at y=2 of a fresh frame.
- Width rules: line_width and frame_lines need not be powers of two; counters compare explicitly against the parameter values minus 1.

Test Plan:
- Setup: line_width=4, frame_lines=4, out_ready=1, continuous input pixels 0,1,2,…,15.
  - Outputs start with the 9th accept (pixel 8). First output: out_col={0,4,8}, out_x=0, out_y=2, out_sof=1, out_sol=1.
  - Last output: {7,11,15}, x=3, y=3, out_eof=1. frames_done=1. Exactly 8 outputs.
- Two back-to-back frames:
  - Second frame, first column = {F2 row0 x0, F2 row1 x0, F2 row2 x0}, with no mixing from frame 1. frames_done=2.
- Back-pressure: drop out_ready for 5 cycles mid line 3.
  - out_col/out_x hold constant, in_ready=0 after the first buffered output, no pixels lost or duplicated.
  - The column sequence matches the no-stall reference.
- Read-during-write: alternate in_valid 1/0 and also drive it constantly.
  - Columns are identical in both cases, confirming old-data reads at the same address.
- frame_restart asserted at (x=2, y=3) while out_valid=1:
  - The pending output is dropped and the next accepted pixel becomes (0,0).
  - The first later output has out_y=2, out_sof=1. frames_done is unchanged.
- pclk_reset_n low for 1 cycle mid-frame:
  - All outputs return to their reset values and frames_done=0.
  - The following full frame produces exactly (frame_lines-2)*line_width correct columns.
